// File: rtl/fifo_burst_ctrl_if.sv
// FIFO read side and memory write side of the burst controller, bundled as one bus.
interface fifo_burst_ctrl_if #(
  parameter int DATA_WIDTH       = 16,
  parameter int FIFO_DEPTH_WIDTH = 10,
  parameter int ADDR_WIDTH       = 17
);
  logic [FIFO_DEPTH_WIDTH-1:0] fifo_count;
  logic                        fifo_empty;
  logic [DATA_WIDTH-1:0]       fifo_data;
  logic                        fifo_read;
  logic                        mem_req;
  logic                        mem_gnt;
  logic                        mem_wr;
  logic [ADDR_WIDTH-1:0]       mem_addr;
  logic [DATA_WIDTH-1:0]       mem_data;

  modport master (
    input  fifo_count, fifo_empty, fifo_data, mem_gnt,
    output fifo_read, mem_req, mem_wr, mem_addr, mem_data
  );

  modport slave (
    output fifo_count, fifo_empty, fifo_data, mem_gnt,
    input  fifo_read, mem_req, mem_wr, mem_addr, mem_data
  );
endinterface

// File: rtl/fifo_burst_ctrl.sv
// Drains a first-word-fall-through FIFO into memory in bursts of BURST_LEN words,
// walking a frame-sized write address that wraps at FRAME_WORDS.
module fifo_burst_ctrl #(
  parameter int DATA_WIDTH       = 16,
  parameter int FIFO_DEPTH_WIDTH = 10,
  parameter int BURST_LEN        = 8,
  parameter int FRAME_WORDS      = 76800,
  parameter int ADDR_WIDTH       = 17
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 flush,
  input  logic                 frame_sync,
  fifo_burst_ctrl_if.master    bus,
  output logic                 frame_done,
  output logic                 busy
);

  localparam logic [7:0]                  LAST_BEAT = 8'(BURST_LEN - 1);
  localparam logic [FIFO_DEPTH_WIDTH-1:0] BURST_CNT = FIFO_DEPTH_WIDTH'(BURST_LEN);
  localparam logic [ADDR_WIDTH-1:0]       LAST_ADDR = ADDR_WIDTH'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {IDLE, REQ, BURST} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [7:0]            beat_cnt;
  logic                  sync_pending;
  logic                  partial;
  logic                  frame_done_q;

  logic start;
  logic beat;
  logic at_frame_end;
  logic enter_idle;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    start        = enable && ((bus.fifo_count >= BURST_CNT) || (flush && !bus.fifo_empty));
    beat         = (state == BURST) && !bus.fifo_empty;
    at_frame_end = (addr == LAST_ADDR);
    state_nxt    = state;

    unique case (state)
      IDLE:  if (start) state_nxt = REQ;
      REQ:   if (bus.mem_gnt) state_nxt = BURST;
      BURST: begin
        // Frame end and full burst both close on the beat; a flush burst closes once the FIFO runs dry.
        if (beat && (at_frame_end || beat_cnt == LAST_BEAT))
          state_nxt = IDLE;
        else if (!beat && partial && beat_cnt != 8'd0)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    enter_idle = (state != IDLE) && (state_nxt == IDLE);
  end

  assign bus.fifo_read = beat;
  assign bus.mem_wr    = beat;
  assign bus.mem_data  = bus.fifo_data;
  assign bus.mem_addr  = addr;
  assign bus.mem_req   = (state != IDLE);
  assign busy          = (state != IDLE);
  assign frame_done    = frame_done_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      addr         <= '0;
      beat_cnt     <= '0;
      sync_pending <= 1'b0;
      partial      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      frame_done_q <= beat && at_frame_end;

      if (state == REQ && bus.mem_gnt)
        beat_cnt <= '0;
      else if (beat)
        beat_cnt <= beat_cnt + 8'd1;

      if (state == IDLE && start)
        partial <= (bus.fifo_count < BURST_CNT);

      // A restart request never disturbs a running burst; it lands when the burst closes.
      if ((state == IDLE && frame_sync) || (enter_idle && (sync_pending || frame_sync)))
        addr <= '0;
      else if (beat)
        addr <= at_frame_end ? '0 : addr + ADDR_WIDTH'(1);

      if (enter_idle)
        sync_pending <= 1'b0;
      else if (state != IDLE && frame_sync)
        sync_pending <= 1'b1;
    end
  end

endmodule
